// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared memory-port constants, request type and IO-window decode.
package mem_io_responder_pkg;
  typedef logic [31:0] addr_t;
  localparam addr_t RAM_IO_ADDRESS = 32'h0003_0000;
  localparam addr_t RAM_IO_STATUS_ADDRESS = 32'h0003_0004;
  localparam logic READ_FLAG = 1'b0;
  localparam logic WRITE_FLAG = 1'b1;
  typedef struct packed {
    logic rw;
    addr_t addr;
    logic [7:0] din;
  } memport_t;
  function automatic logic is_io(addr_t a);
    return a[17:16] == 2'b11;
  endfunction
endpackage

// File: rtl/mem_io_responder_io_tx_fifo.sv
// io_tx_fifo: circular byte FIFO feeding the console sink; head reads as zero when empty.
module io_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign head = empty ? 8'h00 : mem_q[rd_q];
  assign do_pop = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (cnt_q != (AW+1)'(DEPTH) || do_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus console IO window with TX FIFO back-pressure.
// SIM_HALT_EN adds the sticky sim_halt output set by a write to the status address.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rw_flag,
  input  logic [31:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef SIM_HALT_EN
  , output logic      sim_halt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  memport_t req;
  logic [7:0] mem [2**RAM_ADDR_WIDTH];
  logic [7:0] dout_q, io_rd;
  logic [RAM_ADDR_WIDTH-1:0] ram_a;
  logic [CW-1:0] cnt;
  logic io, wr, rd, push, empty;
  assign req = '{rw: rw_flag, addr: addr, din: din};
  assign io = is_io(req.addr);
  assign wr = rdy && req.rw == WRITE_FLAG;
  assign rd = rdy && req.rw == READ_FLAG;
  assign ram_a = req.addr[RAM_ADDR_WIDTH-1:0];
  assign push = wr && req.addr == RAM_IO_ADDRESS;
  assign io_rd = req.addr == RAM_IO_STATUS_ADDRESS ? 8'(cnt) : 8'h00;
  assign dout = dout_q;
  assign tx_valid = !empty;
  // two entries of headroom absorb a write already issued by the controller
  assign io_buffer_full = cnt >= CW'(FIFO_DEPTH - 2);
  always_ff @(posedge clk) if (wr && !io) mem[ram_a] <= req.din;
  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else if (rd) dout_q <= io ? io_rd : mem[ram_a];
  end
  io_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(req.din),
    .pop(tx_valid && tx_ready),
    .head(tx_data),
    .empty(empty),
    .count(cnt)
  );
`ifdef SIM_HALT_EN
  logic halt_q;
  assign sim_halt = halt_q;
  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else if (wr && req.addr == RAM_IO_STATUS_ADDRESS) halt_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed plus random stimulus against a queue-based model of the responder.
module tb_mem_io_responder;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, rdy = 0, rw_flag = 0, tx_ready = 0;
  logic [31:0] addr = 0;
  logic [7:0] din = 0, dout, tx_data;
  logic io_buffer_full, tx_valid;
  logic sim_halt;
  int total = 0, bad = 0;
  mem_io_responder #(.RAM_ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rw_flag(rw_flag), .addr(addr), .din(din),
    .dout(dout), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef SIM_HALT_EN
    , .sim_halt(sim_halt)
`endif
  );
`ifndef SIM_HALT_EN
  assign sim_halt = 1'b0;
`endif
  always #5 clk = ~clk;

  logic [7:0] mm [131072];
  bit wr_ok [131072];
  logic [7:0] q [$];
  logic [7:0] m_dout;
  bit m_known, m_halt, en, m_pop, m_io;
  logic [16:0] m_a;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_dout = 0;
      m_known = 1;
      m_halt = 0;
      en = 1;
    end else begin
      m_pop = q.size() > 0 && tx_ready;
      m_a = addr[16:0];
      m_io = addr[17:16] == 2'b11;
      if (rdy && !rw_flag) begin
        if (m_io) begin
          m_dout = addr == 32'h30004 ? 8'(q.size()) : 8'h00;
          m_known = 1;
        end else begin
          m_dout = mm[m_a];
          m_known = wr_ok[m_a];
        end
      end
      if (m_pop) void'(q.pop_front());
      if (rdy && rw_flag) begin
        if (!m_io) begin
          mm[m_a] = din;
          wr_ok[m_a] = 1;
        end else if (addr == 32'h30000) begin
          if (q.size() < DEPTH) q.push_back(din);
        end else if (addr == 32'h30004) m_halt = 1;
      end
    end
  end

  always @(negedge clk) if (en) begin
    if (m_known) chk("dout", dout, m_dout);
    chk("tx_valid", tx_valid, q.size() > 0);
    if (q.size() > 0) chk("tx_data", tx_data, q[0]);
    chk("io_buffer_full", io_buffer_full, q.size() >= DEPTH - 2);
`ifdef SIM_HALT_EN
    chk("sim_halt", sim_halt, m_halt);
`endif
  end

  task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [7:0] d,
                     input bit tr, input bit rs = 0);
    rst = rs; rdy = r; rw_flag = w; addr = a; din = d; tx_ready = tr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b [6];
    logic [31:0] ra;
    b = '{8'h48, 8'h69, 8'h01, 8'h02, 8'h03, 8'h04};
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_dout", dout, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_full", io_buffer_full, 0);
    chk("rst_halt", sim_halt, 0);
    cyc(1, 1, 32'h100, 8'hA5, 0);
    chk("wr_holds_dout", dout, 0);
    cyc(1, 0, 32'h100, 0, 0);
    chk("rd_after_wr", dout, 8'hA5);
    for (int i = 0; i < 4; i++) cyc(1, 1, i, 8'(8'h11 * (i + 1)), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, i, 0, 0);
      chk("stream_rd", dout, 8'h11 * (i + 1));
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 32'h30000, b[i], 0);
      if (i == 4) chk("full_after_5", io_buffer_full, 0);
      if (i == 5) chk("full_after_6", io_buffer_full, 1);
    end
    chk("head_H", tx_data, 8'h48);
    cyc(0, 0, 0, 0, 1);
    chk("full_drop_pop", io_buffer_full, 0);
    chk("head_i", tx_data, 8'h69);
    for (int i = 5; i < 8; i++) cyc(1, 1, 32'h30000, 8'(i), 0);
    cyc(1, 1, 32'h30000, 8'hEE, 0);
    cyc(1, 0, 32'h30004, 0, 0);
    chk("count_after_drop", dout, 8);
    cyc(1, 1, 32'h30000, 8'h08, 1);
    cyc(1, 0, 32'h30004, 0, 0);
    chk("count_push_pop_full", dout, 8);
    chk("head_after_pp", tx_data, 8'h01);
    cyc(0, 1, 32'h100, 8'h5A, 1);
    cyc(0, 1, 32'h30000, 8'h77, 1);
    cyc(1, 0, 32'h100, 0, 0);
    chk("rdy0_no_wr", dout, 8'hA5);
    cyc(1, 0, 32'h30004, 0, 0);
    chk("rdy0_drain", dout, 6);
    chk("head_3", tx_data, 8'h03);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_mid_valid", tx_valid, 0);
    cyc(1, 0, 32'h30004, 0, 0);
    chk("rst_mid_count", dout, 0);
`ifdef SIM_HALT_EN
    cyc(1, 1, 32'h30004, 8'hFF, 0);
    chk("halt_set", sim_halt, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h30000, 8'(i), 0);
    cyc(1, 0, 32'h30004, 0, 0);
    chk("status_3", dout, 3);
    chk("halt_held", sim_halt, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("halt_cleared", sim_halt, 0);
`endif
    for (int n = 0; n < 3000; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: ra = 32'h30000;
          2: ra = 32'h30004;
          default: ra = {ra[31:18], 2'b11, 8'h00, ra[7:0]};
        endcase
      end else begin
        if (ra[17:16] == 2'b11) ra[17] = 1'b0;
        ra[15:6] = '0;
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), ra, 8'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
